// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - register map, FSM states and read mux for spi_reg_bridge
//
// Shared definitions for the SPI command/register bridge:
//   - fixed ID values returned at 0x00/0x01
//   - register addresses, command write-bit position
//   - FSM state enum
//   - reg_read(): register read mux, snapshot passed in so the caller picks
//     which ADC image (live or frozen) a read sees
//   - sat_inc(): saturating 8-bit increment for ERR_CNT
package spi_reg_pkg;

  localparam logic [7:0] FPGA_VER = 8'hC0;
  localparam logic [7:0] BOARD_ID = 8'hAE;

  localparam logic [6:0] ADDR_VER      = 7'h00;
  localparam logic [6:0] ADDR_ID       = 7'h01;
  localparam logic [6:0] ADDR_ADC_BASE = 7'h02;
  localparam logic [6:0] ADDR_CTRL     = 7'h10;
  localparam logic [6:0] ADDR_SCRATCH  = 7'h11;
  localparam logic [6:0] ADDR_ERR      = 7'h12;

  localparam int CMD_WRITE_BIT = 7;
  localparam int ADC_W         = 60;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_READ,
    ST_WRITE
  } state_e;

  // ADC snapshot is five 12-bit channels, ch0 in [11:0]; each channel is
  // exposed as a lo byte followed by a zero-extended hi nibble.
  function automatic logic [7:0] reg_read(input logic [6:0]       addr,
                                          input logic [ADC_W-1:0] snap,
                                          input logic [1:0]       ctrl,
                                          input logic [7:0]       scratch,
                                          input logic [7:0]       err_cnt);
    logic [7:0] r;
    r = 8'h00;
    case (addr)
      ADDR_VER:              r = FPGA_VER;
      ADDR_ID:               r = BOARD_ID;
      ADDR_ADC_BASE + 7'd0:  r = snap[7:0];
      ADDR_ADC_BASE + 7'd1:  r = {4'b0000, snap[11:8]};
      ADDR_ADC_BASE + 7'd2:  r = snap[19:12];
      ADDR_ADC_BASE + 7'd3:  r = {4'b0000, snap[23:20]};
      ADDR_ADC_BASE + 7'd4:  r = snap[31:24];
      ADDR_ADC_BASE + 7'd5:  r = {4'b0000, snap[35:32]};
      ADDR_ADC_BASE + 7'd6:  r = snap[43:36];
      ADDR_ADC_BASE + 7'd7:  r = {4'b0000, snap[47:44]};
      ADDR_ADC_BASE + 7'd8:  r = snap[55:48];
      ADDR_ADC_BASE + 7'd9:  r = {4'b0000, snap[59:56]};
      ADDR_CTRL:             r = {6'b000000, ctrl};
      ADDR_SCRATCH:          r = scratch;
      ADDR_ERR:              r = err_cnt;
      default:               r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// rtl/spi_reg_bridge_if.sv - byte-level link between spi_slave and spi_reg_bridge
//
// Signals:
//   spi_ss                 chip select from pad, active-low, asynchronous
//   spi_rx_byte_available  level, rising edge = new received byte (async)
//   spi_rx_byte[7:0]       received byte, stable while available is high
//   spi_tx_ready_to_write  level, rising edge = load next tx byte (async)
//   spi_tx_byte[7:0]       byte handed back to spi_slave
// Modports: master = spi_slave side, slave = register bridge side.
interface spi_reg_bridge_if;

  logic       spi_ss;
  logic       spi_rx_byte_available;
  logic [7:0] spi_rx_byte;
  logic       spi_tx_ready_to_write;
  logic [7:0] spi_tx_byte;

  modport master (
    output spi_ss,
    output spi_rx_byte_available,
    output spi_rx_byte,
    output spi_tx_ready_to_write,
    input  spi_tx_byte
  );

  modport slave (
    input  spi_ss,
    input  spi_rx_byte_available,
    input  spi_rx_byte,
    input  spi_tx_ready_to_write,
    output spi_tx_byte
  );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchronizer with registered rise/fall pulses
//
// Ports:
//   in_CLK   system clock
//   reset_n  asynchronous active-low reset
//   async_i  asynchronous level input
//   rise_o   one-cycle pulse, 3 clocks after async_i rises
//   fall_o   one-cycle pulse, 3 clocks after async_i falls
module sync_edge (
  input  logic in_CLK,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] are the metastability pair; [2] holds the previous synced level.
  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  always_ff @(posedge in_CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 3'b000;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI command decoder and register file with auto-increment
//
// Ports:
//   in_CLK, reset_n          clock, asynchronous active-low reset
//   spi                      spi_reg_bridge_if.slave byte link to spi_slave
//   adc_sample_valid         one-cycle pulse: adc_sample_data holds a new set
//   adc_sample_data[59:0]    {ch4,ch3,ch2,ch1,ch0}, 12 bits each
//   ctrl_adc_en              CTRL[0]
//   ctrl_bootloader_force    CTRL[1]
//
// First byte after select is the command (bit7 write, [6:0] start address).
// Reads stage reg[addr] into tx_buffer on each received byte, so the data
// for byte N+1 is ready when spi_slave asks for it. Writes land on each
// received byte. The address wraps within 7 bits.
module spi_reg_bridge
  import spi_reg_pkg::*;
(
  input  logic             in_CLK,
  input  logic             reset_n,
  spi_reg_bridge_if.slave  spi,
  input  logic             adc_sample_valid,
  input  logic [ADC_W-1:0] adc_sample_data,
  output logic             ctrl_adc_en,
  output logic             ctrl_bootloader_force
);

  logic ss_rise, ss_fall;
  logic rx_rise, rx_fall;
  logic tx_rise, tx_fall;

  sync_edge u_sync_ss (
    .in_CLK  (in_CLK),
    .reset_n (reset_n),
    .async_i (spi.spi_ss),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  sync_edge u_sync_rx (
    .in_CLK  (in_CLK),
    .reset_n (reset_n),
    .async_i (spi.spi_rx_byte_available),
    .rise_o  (rx_rise),
    .fall_o  (rx_fall)
  );

  sync_edge u_sync_tx (
    .in_CLK  (in_CLK),
    .reset_n (reset_n),
    .async_i (spi.spi_tx_ready_to_write),
    .rise_o  (tx_rise),
    .fall_o  (tx_fall)
  );

  // Only the rising edges of the byte strobes carry meaning.
  logic unused_edges;
  assign unused_edges = rx_fall ^ tx_fall;

  state_e           state_q,   state_d;
  logic [6:0]       addr_q,    addr_d;
  logic [7:0]       tx_buf_q,  tx_buf_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [1:0]       ctrl_q,    ctrl_d;
  logic [7:0]       scratch_q, scratch_d;
  logic [7:0]       err_q,     err_d;
  logic [ADC_W-1:0] live_q,    live_d;
  logic [ADC_W-1:0] snap_q,    snap_d;

  always_ff @(posedge in_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      tx_buf_q  <= '0;
      tx_byte_q <= '0;
      ctrl_q    <= '0;
      scratch_q <= '0;
      err_q     <= '0;
      live_q    <= '0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_buf_q  <= tx_buf_d;
      tx_byte_q <= tx_byte_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      err_q     <= err_d;
      live_q    <= live_d;
      snap_q    <= snap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_buf_d  = tx_buf_q;
    tx_byte_d = tx_byte_q;
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    err_d     = err_q;
    live_d    = adc_sample_valid ? adc_sample_data : live_q;
    snap_d    = snap_q;

    if (tx_rise) begin
      tx_byte_d = tx_buf_q;
    end

    // Select changes take priority; a byte arriving in the same cycle is dropped.
    if (ss_rise) begin
      state_d = ST_IDLE;
    end else if (ss_fall) begin
      state_d  = ST_CMD;
      tx_buf_d = 8'h00;
    end else if (rx_rise) begin
      case (state_q)
        ST_CMD: begin
          addr_d = spi.spi_rx_byte[6:0];
          if (spi.spi_rx_byte[CMD_WRITE_BIT]) begin
            state_d = ST_WRITE;
          end else begin
            // Freeze the pre-update live value; the first read byte must
            // already come from that frozen image.
            snap_d   = live_q;
            tx_buf_d = reg_read(spi.spi_rx_byte[6:0], live_q, ctrl_q, scratch_q, err_q);
            addr_d   = spi.spi_rx_byte[6:0] + 7'd1;
            state_d  = ST_READ;
          end
        end
        ST_READ: begin
          tx_buf_d = reg_read(addr_q, snap_q, ctrl_q, scratch_q, err_q);
          addr_d   = addr_q + 7'd1;
        end
        ST_WRITE: begin
          case (addr_q)
            ADDR_CTRL:    ctrl_d    = spi.spi_rx_byte[1:0];
            ADDR_SCRATCH: scratch_d = spi.spi_rx_byte;
            ADDR_ERR:     err_d     = 8'h00;
            default:      err_d     = sat_inc(err_q);
          endcase
          addr_d = addr_q + 7'd1;
        end
        default: ;
      endcase
    end
  end

  assign spi.spi_tx_byte      = tx_byte_q;
  assign ctrl_adc_en           = ctrl_q[0];
  assign ctrl_bootloader_force = ctrl_q[1];

endmodule
